// File: rtl/offset_addr_arbiter.sv
// Two-requester round-robin arbiter feeding a one-deep result register.
// The result is base plus the sign-extended offset, with a signed-overflow flag.
module offset_addr_arbiter #(
  parameter int unsigned OFF_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_base,
  input  logic [OFF_W-1:0] req0_off,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_base,
  input  logic [OFF_W-1:0] req1_off,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [31:0]      out_addr,
  output logic             out_id,
  output logic             out_ovf,
  input  logic             out_ready
);

  logic             prio_q;
  logic             out_valid_q;
  logic [31:0]      out_addr_q;
  logic             out_id_q;
  logic             out_ovf_q;

  logic             slot_free;
  logic             grant0;
  logic             grant1;
  logic [31:0]      sel_base;
  logic [OFF_W-1:0] sel_off;
  logic [31:0]      sext_off;
  logic [31:0]      sum;
  logic             ovf;

  assign slot_free = !out_valid_q || out_ready;

  // prio names the requester that wins when both are valid
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && slot_free) begin
      if (req0_valid && (!req1_valid || !prio_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign sel_base = grant1 ? req1_base : req0_base;
  assign sel_off  = grant1 ? req1_off  : req0_off;
  assign sext_off = {{(32 - OFF_W){sel_off[OFF_W-1]}}, sel_off};
  assign sum      = sel_base + sext_off;
  // Overflow only possible when both operands share a sign and the sum flips it
  assign ovf      = (sel_base[31] == sext_off[31]) && (sum[31] != sel_base[31]);

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= 32'd0;
      out_id_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (grant0 || grant1) begin
      prio_q      <= grant0;
      out_valid_q <= 1'b1;
      out_addr_q  <= sum;
      out_id_q    <= grant1;
      out_ovf_q   <= ovf;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_id     = out_id_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_offset_addr_arbiter.sv
// Scoreboard bench for offset_addr_arbiter: directed vectors push expected results,
// a monitor pops and compares on every consumer handshake.
module tb_offset_addr_arbiter;

  localparam int unsigned OFF_W = 19;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [31:0]      req0_base, req1_base;
  logic [OFF_W-1:0] req0_off, req1_off;
  logic             req0_ready, req1_ready;
  logic             out_valid;
  logic [31:0]      out_addr;
  logic             out_id;
  logic             out_ovf;
  logic             out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // {addr, id, ovf}
  logic [33:0] exp_q[$];

  offset_addr_arbiter #(.OFF_W(OFF_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_base  (req0_base),
    .req0_off   (req0_off),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_base  (req1_base),
    .req1_off   (req1_off),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_id     (out_id),
    .out_ovf    (out_ovf),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumer handshake must match the oldest expected result
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got addr 0x%08h id %0d, expected none", out_addr,
                 out_id);
      end else begin
        e = exp_q.pop_front();
        chk("out_addr", out_addr, e[33:2]);
        chk("out_id", {31'd0, out_id}, {31'd0, e[1]});
        chk("out_ovf", {31'd0, out_ovf}, {31'd0, e[0]});
      end
    end
  end

  // Called at posedge+1: drive one cycle, check readies/out_valid mid-cycle, queue result
  task automatic step(input logic v0, input logic [31:0] b0, input logic [OFF_W-1:0] o0,
                      input logic v1, input logic [31:0] b1, input logic [OFF_W-1:0] o1,
                      input logic ordy, input logic er0, input logic er1, input logic eov,
                      input logic [31:0] ea, input logic eovf);
    req0_valid = v0;
    req0_base  = b0;
    req0_off   = o0;
    req1_valid = v1;
    req1_base  = b1;
    req1_off   = o1;
    out_ready  = ordy;
    @(negedge clk);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, er0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, er1});
    chk("out_valid", {31'd0, out_valid}, {31'd0, eov});
    if (er0 || er1) exp_q.push_back({ea, er1, eovf});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input logic eov);
    step(1'b0, 32'd0, '0, 1'b0, 32'd0, '0, ordy, 1'b0, 1'b0, eov, 32'd0, 1'b0);
  endtask

  // One reset cycle with both requesters valid; anything held is discarded
  task automatic reset_cycle();
    rst        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    out_ready  = 1'b0;
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_id", {31'd0, out_id}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_base  = '0;
    req1_base  = '0;
    req0_off   = '0;
    req1_off   = '0;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;
    reset_cycle();

    // Offset arithmetic: -1, overflow into bit 31, most-negative offset
    step(1'b1, 32'h0000_1000, 19'h7FFFF, 1'b0, 32'd0, '0, 1'b1,
         1'b1, 1'b0, 1'b0, 32'h0000_0FFF, 1'b0);
    step(1'b0, 32'd0, '0, 1'b1, 32'h7FFF_FFFF, 19'h00001, 1'b1,
         1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1);
    step(1'b1, 32'h0004_0000, 19'h40000, 1'b0, 32'd0, '0, 1'b1,
         1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Round robin from reset: ids 0,1,0,1 back to back
    reset_cycle();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h0000_0100, 19'h00010, 1'b1, 32'h0000_0200, 19'h7FFF0, 1'b1,
           (i % 2) == 0, (i % 2) == 1, i != 0,
           ((i % 2) == 0) ? 32'h0000_0110 : 32'h0000_01F0, 1'b0);
    end

    // Stall: held result from requester 1 must not move, no grants
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0000_0100, 19'h00010, 1'b1, 32'h0000_0200, 19'h7FFF0, 1'b0,
           1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
      chk("stall_addr", out_addr, 32'h0000_01F0);
      chk("stall_id", {31'd0, out_id}, 32'd1);
    end
    // Release: requester 0 (prio) granted in the same cycle as the handshake
    step(1'b1, 32'h0000_0100, 19'h00010, 1'b1, 32'h0000_0200, 19'h7FFF0, 1'b1,
         1'b1, 1'b0, 1'b1, 32'h0000_0110, 1'b0);
    idle(1'b0, 1'b1);

    // Reset while holding a result with prio=1; first grant afterwards is requester 0
    reset_cycle();
    step(1'b1, 32'h0000_0100, 19'h00010, 1'b1, 32'h0000_0200, 19'h7FFF0, 1'b1,
         1'b1, 1'b0, 1'b0, 32'h0000_0110, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/offset_addr_arbiter.md
OFFSET_ADDR_ARBITER -- requirements
Module: offset_addr_arbiter

Interface
REQ-001 The block SHALL have parameter OFF_W, default 19, giving the width of the signed offset field.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1, the rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 The block SHALL have port req0_valid, input, 1, meaning the branch-target requester has a request.
REQ-006 The block SHALL have port req0_base, input, 32, the branch-target base (PC).
REQ-007 The block SHALL have port req0_off, input, OFF_W, the signed branch offset.
REQ-008 The block SHALL have port req0_ready, output, 1, meaning the request-0 transfer is accepted.
REQ-009 The block SHALL have ports req1_valid, req1_base and req1_off, inputs, 1/32/OFF_W, for the load/store address requester.
REQ-010 The block SHALL have port req1_ready, output, 1, meaning the request-1 transfer is accepted.
REQ-011 The block SHALL have port out_valid, output, 1, meaning a result is held.
REQ-012 The block SHALL have port out_addr, output, 32, the computed address.
REQ-013 The block SHALL have port out_id, output, 1, the requester index of the result.
REQ-014 The block SHALL have port out_ovf, output, 1, the signed-overflow flag.
REQ-015 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.

Function
REQ-016 The block SHALL define slot_free = !out_valid || out_ready.
REQ-017 A transfer SHALL occur on a rising edge where reqN_valid && reqN_ready.
REQ-018 A consumer handshake SHALL occur where out_valid && out_ready.
REQ-019 The block SHALL sign-extend reqN_off to 32 bits by replicating bit OFF_W-1 into bits 31:OFF_W.
REQ-020 The block SHALL compute sum = base + sext(off) modulo 2^32.
REQ-021 The block SHALL set ovf = 1 when base[31] == sext[31] and sum[31] != base[31], and 0 otherwise.
REQ-022 The block SHALL keep a 1-bit round-robin pointer prio; prio=i means requester i wins a tie.
REQ-023 If slot_free and exactly one reqN_valid is high, the block SHALL grant that requester.
REQ-024 If slot_free and both are valid, the block SHALL grant requester prio.
REQ-025 If slot_free is low, the block SHALL grant no requester.
REQ-026 reqN_ready SHALL be high only in a cycle where requester N is granted; it SHALL never be high while reqN_valid is low, and never both in one cycle.
REQ-027 On a grant of requester i, the block SHALL set prio to 1-i on that edge; prio SHALL be unchanged in cycles with no grant.
REQ-028 On a grant, out_addr, out_ovf and out_id SHALL load on that edge, and out_valid SHALL be 1 in the next cycle; latency is exactly 1 cycle.
REQ-029 With no grant and a consumer handshake, out_valid SHALL go to 0 on that edge.
REQ-030 If a consumer handshake and a new grant occur in the same cycle, the block SHALL load the new result with out_valid remaining 1 and no bubble.
REQ-031 While out_valid && !out_ready, out_addr, out_id and out_ovf SHALL hold stable, and both readies SHALL be 0.
REQ-032 With both requesters continuously valid and out_ready=1, grants SHALL alternate, and neither requester SHALL wait more than one grant of the other.
REQ-033 Requesters hold valid and payload stable until accepted; the block SHALL not be required to detect violations of this.

Reset
REQ-034 While rst=1 at a rising edge, the block SHALL set out_valid=0, out_addr=0, out_id=0, out_ovf=0 and prio=0.
REQ-035 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-036 A result held when rst asserts SHALL be discarded and never presented.
REQ-037 The first grant after reset SHALL go to requester 0 when both requesters are valid.

Verification
REQ-038 Scenario: req0 base=0x00001000, off=0x7FFFF -> req0_ready=1; next cycle out_valid=1, out_addr=0x00000FFF, out_id=0, out_ovf=0.
REQ-039 Scenario: req1 base=0x7FFFFFFF, off=0x00001 -> out_addr=0x80000000, out_id=1, out_ovf=1.
REQ-040 Scenario: req0 base=0x00040000, off=0x40000 -> out_addr=0x00000000, out_ovf=0.
REQ-041 Scenario: from reset, both requesters valid and out_ready=1 for 4 cycles -> out_id sequence is 0,1,0,1 with out_valid continuously 1 after the first cycle.
REQ-042 Scenario: out_valid=1, out_ready=0 for 3 cycles with both requesters valid -> outputs stable and readies 0; when out_ready=1, req(prio)_ready=1 in the same cycle and the new result appears next cycle.
REQ-043 Scenario: rst=1 for one cycle while out_valid=1 and prio=1 -> next cycle out_valid=0 and all outputs 0; with both requesters valid, the first grant is to requester 0.
